// File: rtl/output_display_pkg.sv
// Shared types and constants for the seven-segment output display block.
package output_display_pkg;

    localparam int unsigned BCD_W = 12;
    localparam int unsigned ITER  = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CONV = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}; index 9 is the leftmost entry.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    // Double-dabble correction applied to each BCD nibble before the shift.
    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble plus blank flag to active-low seven-segment pattern.
module seg7_decode
    import output_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_DIGIT[0];
                4'd1:    seg_o = SEG_DIGIT[1];
                4'd2:    seg_o = SEG_DIGIT[2];
                4'd3:    seg_o = SEG_DIGIT[3];
                4'd4:    seg_o = SEG_DIGIT[4];
                4'd5:    seg_o = SEG_DIGIT[5];
                4'd6:    seg_o = SEG_DIGIT[6];
                4'd7:    seg_o = SEG_DIGIT[7];
                4'd8:    seg_o = SEG_DIGIT[8];
                4'd9:    seg_o = SEG_DIGIT[9];
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/output_display.sv
// Captures the output port byte, converts it to BCD and multiplexes it onto
// a 4-digit seven-segment display with leading-zero blanking.
module output_display
    import output_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter bit          COMMON_ANODE = 1'b1
) (
    input  logic             disp_clk,
    input  logic             disp_rst_n,
    input  logic             disp_en,
    input  logic [7:0]       data_in,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_valid,
    output logic             busy
);

    localparam int unsigned     CntW   = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
    localparam logic [6:0]      SegOff = COMMON_ANODE ? 7'h7F : 7'h00;
    localparam logic [3:0]      AnOff  = COMMON_ANODE ? 4'hF : 4'h0;

    state_t           state_q, state_d;
    logic [19:0]      shreg_q, shreg_d, adj;
    logic [2:0]       iter_q, iter_d;
    logic             pend_q, pend_d;
    logic [7:0]       pend_byte_q, pend_byte_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [6:0]       seg_q, seg_d, seg_raw;
    logic [3:0]       an_q, an_d, an_raw;
    logic [3:0]       nib;
    logic             blank;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        iter_d      = iter_q;
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
        bcd_d       = bcd_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        adj = {dd_adj(shreg_q[19:16]), dd_adj(shreg_q[15:12]), dd_adj(shreg_q[11:8]),
               shreg_q[7:0]};

        // Requests arriving while a conversion runs are held; newest wins.
        if (disp_en && state_q != ST_IDLE) begin
            pend_d      = 1'b1;
            pend_byte_d = data_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (disp_en || pend_q) begin
                    shreg_d = {12'b0, disp_en ? data_in : pend_byte_q};
                    iter_d  = 3'd0;
                    busy_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                shreg_d = {adj[18:0], 1'b0};
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'(ITER - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                bcd_d   = shreg_q[19:8];
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        sel_d = (cnt_q == CntMax) ? sel_q + 2'd1 : sel_q;
        case (sel_q)
            2'd0: begin nib = bcd_q[3:0];  blank = 1'b0;                 end
            2'd1: begin nib = bcd_q[7:4];  blank = (bcd_q[11:4] == '0);  end
            2'd2: begin nib = bcd_q[11:8]; blank = (bcd_q[11:8] == '0);  end
            default: begin nib = 4'd0;     blank = 1'b1;                 end
        endcase
        an_raw = ~(4'b0001 << sel_q);
        seg_d  = COMMON_ANODE ? seg_raw : ~seg_raw;
        an_d   = COMMON_ANODE ? an_raw : ~an_raw;
    end

    seg7_decode u_decode (
        .bcd_i   (nib),
        .blank_i (blank),
        .seg_o   (seg_raw)
    );

    always_ff @(posedge disp_clk or negedge disp_rst_n) begin
        if (!disp_rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            iter_q      <= '0;
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
            bcd_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            sel_q       <= '0;
            seg_q       <= SegOff;
            an_q        <= AnOff;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            iter_q      <= iter_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display: one common-anode and one common-cathode instance.
module tb_output_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  data;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic [11:0] bcd_a, bcd_b;
    logic        valid_a, valid_b, busy_a, busy_b;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    output_display #(.REFRESH_DIV(4), .COMMON_ANODE(1'b1)) u_dut (
        .disp_clk   (clk),
        .disp_rst_n (rst_n),
        .disp_en    (en),
        .data_in    (data),
        .seg        (seg_a),
        .an         (an_a),
        .bcd        (bcd_a),
        .bcd_valid  (valid_a),
        .busy       (busy_a)
    );

    output_display #(.REFRESH_DIV(4), .COMMON_ANODE(1'b0)) u_dut_ca0 (
        .disp_clk   (clk),
        .disp_rst_n (rst_n),
        .disp_en    (en),
        .data_in    (data),
        .seg        (seg_b),
        .an         (an_b),
        .bcd        (bcd_b),
        .bcd_valid  (valid_b),
        .busy       (busy_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses disp_en for one edge (k) and returns at the k+9 sample point.
    task automatic convert(input logic [7:0] v);
        en   = 1'b1;
        data = v;
        tick();
        en = 1'b0;
        repeat (9) tick();
    endtask

    task automatic wait_an(input logic [3:0] target, input bit use_ca0, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((use_ca0 ? an_b : an_a) == target) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        bit         f;
        int         vcnt;
        logic [3:0] exp_an;

        rst_n = 1'b1;
        en    = 1'b0;
        data  = 8'h00;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst bcd", bcd_a, 12'h000);
        check("rst valid", valid_a, 1'b0);
        check("rst busy", busy_a, 1'b0);
        check("rst seg ca1", seg_a, 7'h7F);
        check("rst an ca1", an_a, 4'hF);
        check("rst seg ca0", seg_b, 7'h00);
        check("rst an ca0", an_b, 4'h0);
        rst_n = 1'b1;
        tick();

        // 255: busy k..k+8, result at k+9
        check("idle busy", busy_a, 1'b0);
        en   = 1'b1;
        data = 8'hFF;
        tick();
        en = 1'b0;
        check("ff busy k", busy_a, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("ff busy conv", busy_a, 1'b1);
            check("ff valid conv", valid_a, 1'b0);
        end
        tick();
        check("ff bcd", bcd_a, 12'h255);
        check("ff valid", valid_a, 1'b1);
        check("ff busy done", busy_a, 1'b0);
        tick();
        check("ff valid one cycle", valid_a, 1'b0);
        check("ff bcd hold", bcd_a, 12'h255);

        // Asynchronous reset at k+4 of a conversion
        en   = 1'b1;
        data = 8'd123;
        tick();
        en = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async bcd", bcd_a, 12'h000);
        check("async busy", busy_a, 1'b0);
        check("async seg", seg_a, 7'h7F);
        check("async an", an_a, 4'hF);
        tick();
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid_a) vcnt++;
        end
        check("post rst bcd", bcd_a, 12'h000);
        check("post rst busy", busy_a, 1'b0);
        check("post rst no valid", vcnt, 0);

        // Zero: only digit 0 lit
        convert(8'h00);
        check("zero valid", valid_a, 1'b1);
        check("zero bcd", bcd_a, 12'h000);
        repeat (2) tick();
        wait_an(4'b1011, 1'b0, f);
        check("zero find d2", f, 1'b1);
        check("zero d2 blank", seg_a, 7'h7F);
        wait_an(4'b1101, 1'b0, f);
        check("zero find d1", f, 1'b1);
        check("zero d1 blank", seg_a, 7'h7F);
        wait_an(4'b1110, 1'b0, f);
        check("zero find d0", f, 1'b1);
        check("zero d0", seg_a, 7'b1000000);

        // 105: inner zero must stay visible
        convert(8'd105);
        check("105 bcd", bcd_a, 12'h105);
        repeat (2) tick();
        wait_an(4'b1101, 1'b0, f);
        check("105 find d1", f, 1'b1);
        check("105 d1", seg_a, 7'b1000000);
        wait_an(4'b1011, 1'b0, f);
        check("105 find d2", f, 1'b1);
        check("105 d2", seg_a, 7'b1111001);
        wait_an(4'b1110, 1'b0, f);
        check("105 find d0", f, 1'b1);
        check("105 d0", seg_a, 7'b0010010);

        // Digit rotation, 4 cycles per digit, digit 3 blank
        wait_an(4'b0111, 1'b0, f);
        check("rot find d3", f, 1'b1);
        for (int i = 0; i < 6 && an_a == 4'b0111; i++) tick();
        for (int i = 0; i < 16; i++) begin
            case (i / 4)
                0:       exp_an = 4'b1110;
                1:       exp_an = 4'b1101;
                2:       exp_an = 4'b1011;
                default: exp_an = 4'b0111;
            endcase
            check("rot an", an_a, exp_an);
            if (i >= 12) check("rot d3 blank", seg_a, 7'h7F);
            tick();
        end

        // 2A then 07, 63 while busy: 07 is superseded
        en   = 1'b1;
        data = 8'h2A;
        tick();
        data = 8'h07;
        tick();
        en = 1'b0;
        tick();
        en   = 1'b1;
        data = 8'h63;
        tick();
        en   = 1'b0;
        vcnt = 0;
        for (int t = 4; t <= 30; t++) begin
            tick();
            if (valid_a) vcnt++;
            if (t == 9) begin
                check("b2b first bcd", bcd_a, 12'h042);
                check("b2b first valid", valid_a, 1'b1);
                check("b2b gap busy", busy_a, 1'b0);
            end
            if (t == 10) check("b2b reload busy", busy_a, 1'b1);
            if (t == 19) begin
                check("b2b second bcd", bcd_a, 12'h099);
                check("b2b second valid", valid_a, 1'b1);
            end
        end
        check("b2b pulse count", vcnt, 2);
        check("b2b final bcd", bcd_a, 12'h099);

        // Common-cathode polarity with 8
        convert(8'd8);
        check("8 bcd ca0", bcd_b, 12'h008);
        repeat (2) tick();
        wait_an(4'b0001, 1'b1, f);
        check("ca0 find d0", f, 1'b1);
        check("ca0 d0 seg", seg_b, 7'b1111111);
        wait_an(4'b0010, 1'b1, f);
        check("ca0 find d1", f, 1'b1);
        check("ca0 d1 blank", seg_b, 7'b0000000);
        wait_an(4'b1110, 1'b0, f);
        check("ca1 find d0", f, 1'b1);
        check("ca1 d0 eight", seg_a, 7'b0000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
